multdiv_seq: RTL and testbench

- Parametrised iterative signed multiply/divide unit for the DX stage. It is the successor to the fixed 32-bit multdiv used by the pipelined processor.
- Uses a valid/ready handshake on the issue and result sides, and carries a destination-register tag with each operation.
- Provides pipeline flush and distinct exception reporting, so the pipeline can stall on busy and write rstatus on exception.

---
 rtl/multdiv_seq_if.sv | 28 ++
 rtl/multdiv_seq.sv | 140 ++++++++++++++
 tb/tb_multdiv_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_seq_if.sv
// Issue/result bundle for the iterative multiply/divide unit.
// The unit connects as slave; the pipeline connects as master.
interface multdiv_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             op_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op_div, operand_a, operand_b, in_tag, out_ready,
    input  in_ready, out_valid, result, exception, out_tag
  );

  modport slave (
    input  in_valid, op_div, operand_a, operand_b, in_tag, out_ready,
    output in_ready, out_valid, result, exception, out_tag
  );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// operating on magnitudes with a final one-cycle sign fix.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  output logic          busy,
  multdiv_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic               sign_reg;
  logic               div_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               exc_reg;
  logic [TAG_W-1:0]   out_tag_reg;
  logic               out_valid_reg;

  logic               in_ready_int;
  logic               accept;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   fix_result;
  logic               fix_exc;

  // Held low during reset so every output reads zero while reset is asserted.
  assign in_ready_int = reset & ((state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready));
  assign accept       = bus.in_valid & in_ready_int & ~flush;

  assign abs_a = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

  // Multiply: low half holds the multiplier, consumed LSB first while the sum shifts in.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_a_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the LSB.
  assign div_rem  = acc_reg[2*WIDTH-2:WIDTH-1];
  assign div_ge   = div_rem >= mag_b_reg;
  assign div_next = div_ge ? {div_rem - mag_b_reg, acc_reg[WIDTH-2:0], 1'b1}
                           : {acc_reg[2*WIDTH-2:0], 1'b0};

  // A product fits when its top WIDTH+1 bits are all copies of the sign.
  assign prod_signed = sign_reg ? -acc_reg : acc_reg;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign quo_signed  = sign_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign fix_result  = div_reg ? quo_signed : prod_signed[WIDTH-1:0];
  assign fix_exc     = div_reg ? (~sign_reg & acc_reg[WIDTH-1])
                               : ~((&prod_top) | ~(|prod_top));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mag_a_reg     <= '0;
      mag_b_reg     <= '0;
      sign_reg      <= 1'b0;
      div_reg       <= 1'b0;
      tag_reg       <= '0;
      result_reg    <= '0;
      exc_reg       <= 1'b0;
      out_tag_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (state_reg == DONE && bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
          if (accept) begin
            mag_a_reg <= abs_a;
            mag_b_reg <= abs_b;
            sign_reg  <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
            div_reg   <= bus.op_div;
            tag_reg   <= bus.in_tag;
            cnt_reg   <= '0;
            acc_reg   <= {{WIDTH{1'b0}}, (bus.op_div ? abs_a : abs_b)};
            if (bus.op_div && bus.operand_b == '0) begin
              // Divide by zero skips iteration entirely.
              result_reg    <= '0;
              exc_reg       <= 1'b1;
              out_tag_reg   <= bus.in_tag;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          acc_reg <= div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg    <= fix_result;
          exc_reg       <= fix_exc;
          out_tag_reg   <= tag_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.exception = exc_reg;
  assign bus.out_tag   = out_tag_reg;
  assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: literal checks per operation plus a per-cycle
// comparison against an arithmetic model of results, latency and handshake.
module tb_multdiv_seq;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = WIDTH + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  multdiv_seq_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  multdiv_seq #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int               rdy;
    logic [WIDTH-1:0] res;
    logic             exc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Signed arithmetic from first principles; returns {exception, result}.
  function automatic logic [WIDTH:0] model(input logic d, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    longint pa, pb, p;
    logic [WIDTH-1:0] r;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (!d) begin
      p = pa * pb;
      r = p[WIDTH-1:0];
      return {(p != longint'($signed(r))), r};
    end
    if (b == '0) return {1'b1, {WIDTH{1'b0}}};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, a};
    p = pa / pb;
    r = p[WIDTH-1:0];
    return {1'b0, r};
  endfunction

  // Per-cycle compare against the model queue.
  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
    end else begin
      logic ev, er;
      logic [WIDTH:0] m;
      exp_t e;
      ev = (q.size() > 0) && (edge_cnt >= q[0].rdy);
      er = (q.size() == 0) || (ev && bus.out_ready);
      chk("cyc_out_valid", bus.out_valid, ev);
      chk("cyc_in_ready", bus.in_ready, er);
      chk("cyc_busy", busy, q.size() > 0);
      if (ev) begin
        chk("cyc_result", bus.result, q[0].res);
        chk("cyc_exception", bus.exception, q[0].exc);
        chk("cyc_out_tag", bus.out_tag, q[0].tag);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ev && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && er) begin
          m     = model(bus.op_div, bus.operand_a, bus.operand_b);
          e.res = m[WIDTH-1:0];
          e.exc = m[WIDTH];
          e.tag = bus.in_tag;
          e.rdy = edge_cnt + 1 +
                  ((bus.op_div && bus.operand_b == '0) ? 0 : LAT);
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic d, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] t);
    bus.in_valid  = 1'b1;
    bus.op_div    = d;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_tag    = t;
  endtask

  // Waits for out_valid after the accept edge; n counts edges with the accept edge as 1.
  task automatic wait_result(input string name, input int exp_lat, input logic [WIDTH-1:0] exp_res,
                             input logic exp_exc, input logic [TAG_W-1:0] exp_tag);
    int n;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_result"}, bus.result, exp_res);
    chk({name, "_exception"}, bus.exception, exp_exc);
    chk({name, "_tag"}, bus.out_tag, exp_tag);
  endtask

  task automatic run_op(input string name, input logic d, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                        input logic [WIDTH-1:0] exp_res, input logic exp_exc, input int exp_lat);
    chk({name, "_model_pin"}, model(d, a, b), {exp_exc, exp_res});
    present(d, a, b, t);
    tick();
    bus.in_valid = 1'b0;
    wait_result(name, exp_lat, exp_res, exp_exc, t);
  endtask

  initial begin
    logic [WIDTH-1:0] held_res;
    logic             held_exc;
    logic [TAG_W-1:0] held_tag;
    bit               seen;

    bus.in_valid  = 1'b0;
    bus.op_div    = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_outs", {bus.exception, bus.out_tag}, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    tick();

    run_op("mul_7_m6",   0, 32'd7,         -32'sd6,       5'd3,  32'hFFFF_FFD6, 0, LAT + 1);
    tick();
    run_op("mul_ovf",    0, 32'h0001_0000, 32'h0001_0000, 5'd4,  32'h0000_0000, 1, LAT + 1);
    tick();
    run_op("mul_m1_m1",  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 0, LAT + 1);
    tick();
    run_op("mul_min2",   0, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h0000_0000, 1, LAT + 1);
    tick();
    run_op("div_m7_2",   1, -32'sd7,       32'd2,         5'd6,  32'hFFFF_FFFD, 0, LAT + 1);
    tick();
    run_op("div_5_0",    1, 32'd5,         32'd0,         5'd7,  32'h0000_0000, 1, 1);
    tick();
    run_op("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1, LAT + 1);
    tick();
    run_op("div_100_m7", 1, 32'd100,       -32'sd7,       5'd9,  32'hFFFF_FFF2, 0, LAT + 1);
    tick();

    // Backpressure: hold the result, then retire and accept in the same cycle.
    bus.out_ready = 1'b0;
    run_op("bp_first", 0, -32'sd5, 32'd1000, 5'd11, 32'hFFFF_EC78, 0, LAT + 1);
    held_res = bus.result;
    held_exc = bus.exception;
    held_tag = bus.out_tag;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.exception, bus.out_tag, bus.result},
          {1'b1, 1'b0, held_exc, held_tag, held_res});
    end
    bus.out_ready = 1'b1;
    present(0, 32'd3, 32'd3, 5'd12);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_retired", {bus.out_valid, busy}, 2'b01);
    wait_result("bp_second", LAT + 1, 32'd9, 0, 5'd12);
    tick();

    // Flush at RUN cycle 10 alongside a new request.
    present(0, 32'd2, 32'd3, 5'd13);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    present(0, 32'd4, 32'd4, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_output", seen, 0);

    // Asynchronous reset in the middle of RUN.
    present(0, 32'd5, 32'd5, 5'd14);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_outs", {bus.out_valid, bus.in_ready, busy, bus.exception, bus.out_tag}, 0);
    chk("arst_result", bus.result, 0);
    tick();
    reset = 1'b1;
    tick();
    run_op("post_rst_2x2", 0, 32'd2, 32'd2, 5'd15, 32'd4, 0, LAT + 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
